// File: rtl/sweep_sequencer_pkg.sv
// Shared definitions for the solar-tracker sweep sequencer: FSM state codes, width and position defaults.
package sweep_sequencer_pkg;

    localparam int PW_DEF       = 8;
    localparam int LW_DEF       = 12;
    localparam int POS_MAX_DEF  = 180;
    localparam int POS_HOME_DEF = 90;
    localparam int STEP_DEF     = 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_H_SWEEP = 3'd1;
    localparam logic [2:0] ST_H_PARK  = 3'd2;
    localparam logic [2:0] ST_V_SWEEP = 3'd3;
    localparam logic [2:0] ST_V_PARK  = 3'd4;
    localparam logic [2:0] ST_HOLD    = 3'd5;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == ST_H_SWEEP) || (st == ST_H_PARK) ||
               (st == ST_V_SWEEP) || (st == ST_V_PARK);
    endfunction

endpackage

// File: rtl/sweep_sequencer_if.sv
// Control/status bundle between the scan controller and the servo, sensor and end-stop logic.
interface sweep_sequencer_if
    import sweep_sequencer_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int LW = LW_DEF
);
    logic          START;
    logic          TICK;
    logic [LW-1:0] LIGHT;
    logic          LIGHT_VLD;
    logic          PWM_LIMIT_H;
    logic          PWM_LIMIT_V;
    logic          HS;
    logic          VS;
    logic [PW-1:0] H_POS;
    logic [PW-1:0] V_POS;
    logic [LW-1:0] BEST_LIGHT;
    logic          BUSY;
    logic          DONE;

    modport master (
        output START, TICK, LIGHT, LIGHT_VLD, PWM_LIMIT_H, PWM_LIMIT_V,
        input  HS, VS, H_POS, V_POS, BEST_LIGHT, BUSY, DONE
    );

    modport slave (
        input  START, TICK, LIGHT, LIGHT_VLD, PWM_LIMIT_H, PWM_LIMIT_V,
        output HS, VS, H_POS, V_POS, BEST_LIGHT, BUSY, DONE
    );
endinterface

// File: rtl/sweep_sequencer_limit_debounce.sv
// Servo end-stop qualifier: LIM is high only after RAW has been high for LIMIT_CYC consecutive cycles.
module limit_debounce #(
    parameter int LIMIT_CYC = 31
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic RAW,
    output logic LIM
);
    localparam int CW = $clog2(LIMIT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || !EN || !RAW)
            cnt <= '0;
        else if (cnt != CW'(LIMIT_CYC))
            cnt <= cnt + 1'b1;
    end

    assign LIM = (cnt == CW'(LIMIT_CYC));
endmodule

// File: rtl/sweep_sequencer.sv
// Solar-tracker scan controller: H sweep/park, V sweep/park, timed dwell, repeat.
// Optional light hysteresis on capture is enabled by defining SWEEP_HYST_EN.
module sweep_sequencer
    import sweep_sequencer_pkg::*;
#(
    parameter int PW           = PW_DEF,
    parameter int LW           = LW_DEF,
    parameter int POS_MAX      = POS_MAX_DEF,
    parameter int POS_HOME     = POS_HOME_DEF,
    parameter int STEP         = STEP_DEF,
    parameter int SETTLE_TICKS = 25,
    parameter int HOLD_TICKS   = 500,
    parameter int LIMIT_CYC    = 31,
    parameter int HYST         = 16
) (
    input logic              CLK,
    input logic              RST,
    sweep_sequencer_if.slave bus
);
    localparam int TW = $clog2(HOLD_TICKS + 1);

    logic [2:0]    state, state_nxt;
    logic [PW-1:0] h_pos, v_pos, best_pos;
    logic [LW-1:0] best_light;
    logic [TW-1:0] tick_cnt;
    logic          hs, vs, busy, done;
    logic          lim_h, lim_v;

    logic          sweeping, light_gt, capture, end_hit, settle_done, hold_done;
    logic [PW-1:0] cur_pos, next_pos, park_pos;
    logic [PW:0]   pos_sum;

    limit_debounce #(.LIMIT_CYC(LIMIT_CYC)) u_deb_h (
        .CLK(CLK), .RST(RST), .EN(hs), .RAW(bus.PWM_LIMIT_H), .LIM(lim_h)
    );
    limit_debounce #(.LIMIT_CYC(LIMIT_CYC)) u_deb_v (
        .CLK(CLK), .RST(RST), .EN(vs), .RAW(bus.PWM_LIMIT_V), .LIM(lim_v)
    );

`ifdef SWEEP_HYST_EN
    assign light_gt = {1'b0, bus.LIGHT} > ({1'b0, best_light} + (LW+1)'(HYST));
`else
    logic [31:0] unused_hyst;
    assign unused_hyst = 32'(HYST);
    assign light_gt    = bus.LIGHT > best_light;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sweeping    = (state == ST_H_SWEEP) || (state == ST_V_SWEEP);
        cur_pos     = (state == ST_V_SWEEP) ? v_pos : h_pos;
        pos_sum     = {1'b0, cur_pos} + (PW+1)'(STEP);
        next_pos    = (pos_sum > (PW+1)'(POS_MAX)) ? PW'(POS_MAX) : pos_sum[PW-1:0];
        capture     = sweeping && bus.LIGHT_VLD && light_gt;
        // A sample captured on the ending TICK must still steer the park position.
        park_pos    = capture ? cur_pos : best_pos;
        end_hit     = (cur_pos == PW'(POS_MAX)) ||
                      ((state == ST_V_SWEEP) ? lim_v : lim_h);
        settle_done = bus.TICK && (tick_cnt == TW'(SETTLE_TICKS - 1));
        hold_done   = bus.TICK && (tick_cnt == TW'(HOLD_TICKS - 1));

        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.START) state_nxt = ST_H_SWEEP;
            ST_H_SWEEP: if (bus.TICK && end_hit) state_nxt = ST_H_PARK;
            ST_H_PARK:  if (settle_done) state_nxt = ST_V_SWEEP;
            ST_V_SWEEP: if (bus.TICK && end_hit) state_nxt = ST_V_PARK;
            ST_V_PARK:  if (settle_done) state_nxt = ST_HOLD;
            ST_HOLD:    if (bus.START || hold_done) state_nxt = ST_H_SWEEP;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only; later assignments in this block win.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            h_pos      <= PW'(POS_HOME);
            v_pos      <= PW'(POS_HOME);
            best_pos   <= '0;
            best_light <= '0;
            tick_cnt   <= '0;
            hs         <= 1'b0;
            vs         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            hs    <= (state_nxt == ST_H_SWEEP);
            vs    <= (state_nxt == ST_V_SWEEP);
            busy  <= is_busy(state_nxt);
            done  <= (state == ST_V_PARK) && (state_nxt == ST_HOLD);

            if (state_nxt != state)
                tick_cnt <= '0;
            else if (bus.TICK && !sweeping && state != ST_IDLE)
                tick_cnt <= tick_cnt + 1'b1;

            if (capture) begin
                best_light <= bus.LIGHT;
                best_pos   <= cur_pos;
            end

            case (state)
                ST_IDLE, ST_HOLD: if (state_nxt == ST_H_SWEEP) begin
                    h_pos      <= '0;
                    best_light <= '0;
                    best_pos   <= '0;
                end
                ST_H_SWEEP: if (bus.TICK)
                    h_pos <= (state_nxt == ST_H_PARK) ? park_pos : next_pos;
                ST_H_PARK: if (state_nxt == ST_V_SWEEP) begin
                    v_pos      <= '0;
                    best_light <= '0;
                    best_pos   <= '0;
                end
                ST_V_SWEEP: if (bus.TICK)
                    v_pos <= (state_nxt == ST_V_PARK) ? park_pos : next_pos;
                default: ;
            endcase
        end
    end

    assign bus.HS         = hs;
    assign bus.VS         = vs;
    assign bus.H_POS      = h_pos;
    assign bus.V_POS      = v_pos;
    assign bus.BEST_LIGHT = best_light;
    assign bus.BUSY       = busy;
    assign bus.DONE       = done;
endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer: a per-cycle vector table for the sweep start, then hand-written
// multi-cycle sequences for park, hold, end-stop debounce, restart and reset.
module tb_sweep_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sweep_sequencer_if bus ();
    sweep_sequencer dut (.CLK(clk), .RST(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always @(negedge clk) if (bus.DONE) done_cnt++;

    typedef struct {
        logic        start;
        logic        tick;
        logic        vld;
        logic [11:0] light;
        logic [7:0]  exp_h;
        logic [11:0] exp_best;
        logic        exp_hs;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [8];

`ifdef SWEEP_HYST_EN
    localparam logic [11:0] L60 = 12'h50A;
`else
    localparam logic [11:0] L60 = 12'h500;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input logic vld, input logic [11:0] lt);
        bus.TICK      = 1'b1;
        bus.LIGHT_VLD = vld;
        bus.LIGHT     = lt;
        cyc(1);
        bus.TICK      = 1'b0;
        bus.LIGHT_VLD = 1'b0;
        cyc(2);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick(1'b0, 12'h000);
    endtask

    initial begin
        int exp_pos;
        logic [11:0] lt;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 12'h000, 8'd90, 12'h000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 12'h000, 8'd0,  12'h000, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 12'h100, 8'd2,  12'h100, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 12'h0FF, 8'd2,  12'h100, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 12'h300, 8'd2,  12'h300, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 12'h000, 8'd4,  12'h300, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 12'h300, 8'd6,  12'h300, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 12'h000, 8'd6,  12'h300, 1'b1, 1'b1};

        bus.START = 0; bus.TICK = 0; bus.LIGHT = '0; bus.LIGHT_VLD = 0;
        bus.PWM_LIMIT_H = 0; bus.PWM_LIMIT_V = 0;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        check("reset h_pos", bus.H_POS, 90);
        check("reset v_pos", bus.V_POS, 90);
        check("reset best", bus.BEST_LIGHT, 0);
        check("reset hs/vs/busy/done", {bus.HS, bus.VS, bus.BUSY, bus.DONE}, 0);

        // Sweep start, capture, tie and ignored START, one cycle per vector.
        for (int i = 0; i < 8; i++) begin
            bus.START = vecs[i].start; bus.TICK = vecs[i].tick;
            bus.LIGHT_VLD = vecs[i].vld; bus.LIGHT = vecs[i].light;
            cyc(1);
            check($sformatf("vec%0d h_pos", i), bus.H_POS, vecs[i].exp_h);
            check($sformatf("vec%0d best", i), bus.BEST_LIGHT, vecs[i].exp_best);
            check($sformatf("vec%0d hs", i), bus.HS, vecs[i].exp_hs);
            check($sformatf("vec%0d busy", i), bus.BUSY, vecs[i].exp_busy);
        end
        bus.START = 0; bus.TICK = 0; bus.LIGHT_VLD = 0; bus.LIGHT = '0;

        // Horizontal sweep to POS_MAX with a 0x800 peak at position 40.
        exp_pos = 6;
        while (exp_pos < 180) begin
            lt = (exp_pos == 40) ? 12'h800 : 12'h200;
            tick(1'b1, lt);
            exp_pos += 2;
            check($sformatf("h sweep pos %0d", exp_pos), bus.H_POS, exp_pos);
        end
        tick(1'b1, 12'h200);
        check("h park pos", bus.H_POS, 40);
        check("h park best", bus.BEST_LIGHT, 12'h800);
        check("h park hs/busy", {bus.HS, bus.BUSY}, 2'b01);
        check("h park v_pos", bus.V_POS, 90);

        // Settle: 24 TICKs stay parked, START ignored, 25th enters V_SWEEP.
        ticks(24);
        bus.START = 1'b1; cyc(1); bus.START = 1'b0;
        check("settle 24 vs", bus.VS, 0);
        check("settle h_pos", bus.H_POS, 40);
        tick(1'b0, 12'h000);
        check("v sweep entry vs", bus.VS, 1);
        check("v sweep entry v_pos", bus.V_POS, 0);
        check("v sweep entry best", bus.BEST_LIGHT, 0);

        // Vertical sweep with equal (or within-hysteresis) peaks at 20 and 60.
        exp_pos = 0;
        while (exp_pos < 180) begin
            lt = (exp_pos == 20) ? 12'h500 : (exp_pos == 60) ? L60 : 12'h100;
            tick(1'b1, lt);
            exp_pos += 2;
        end
        check("v sweep end pos", bus.V_POS, 180);
        tick(1'b1, 12'h100);
        check("v park pos tie", bus.V_POS, 20);
        check("v park best", bus.BEST_LIGHT, 12'h500);
        check("v park vs", bus.VS, 0);

        // V_PARK -> HOLD with a single-cycle DONE.
        ticks(24);
        check("done before hold", done_cnt, 0);
        bus.TICK = 1'b1; cyc(1); bus.TICK = 1'b0;
        check("done at hold entry", bus.DONE, 1);
        check("busy at hold entry", bus.BUSY, 0);
        cyc(1);
        check("done one cycle", bus.DONE, 0);
        check("done count 1", done_cnt, 1);
        check("hold h_pos", bus.H_POS, 40);
        check("hold v_pos", bus.V_POS, 20);

        // Dwell for HOLD_TICKS, then automatic restart.
        ticks(499);
        check("hold 499 hs", bus.HS, 0);
        check("hold 499 h_pos", bus.H_POS, 40);
        tick(1'b0, 12'h000);
        check("restart hs", bus.HS, 1);
        check("restart h_pos", bus.H_POS, 0);
        check("restart best", bus.BEST_LIGHT, 0);
        check("restart busy", bus.BUSY, 1);

        // Coincident TICK+LIGHT_VLD at H_POS=10, then end-stop debounce.
        ticks(5);
        check("pre coincident pos", bus.H_POS, 10);
        tick(1'b1, 12'h400);
        check("coincident step", bus.H_POS, 12);
        check("coincident best", bus.BEST_LIGHT, 12'h400);
        ticks(2);
        bus.PWM_LIMIT_H = 1'b1; cyc(30); bus.PWM_LIMIT_H = 1'b0;
        tick(1'b0, 12'h000);
        check("glitch 30 ignored pos", bus.H_POS, 18);
        check("glitch 30 ignored hs", bus.HS, 1);
        bus.PWM_LIMIT_H = 1'b1; cyc(31); bus.PWM_LIMIT_H = 1'b0;
        tick(1'b0, 12'h000);
        check("limit 31 park pos", bus.H_POS, 10);
        check("limit 31 hs/busy", {bus.HS, bus.BUSY}, 2'b01);

        // Vertical end-stop with no LIGHT_VLD parks at 0.
        ticks(25);
        check("v2 entry vs", bus.VS, 1);
        ticks(3);
        check("v2 pos", bus.V_POS, 6);
        bus.PWM_LIMIT_V = 1'b1; cyc(31); bus.PWM_LIMIT_V = 1'b0;
        tick(1'b0, 12'h000);
        check("v2 park no vld", bus.V_POS, 0);
        check("v2 park vs", bus.VS, 0);
        ticks(25);
        check("done count 2", done_cnt, 2);

        // START in HOLD restarts on the next edge.
        bus.START = 1'b1; cyc(1); bus.START = 1'b0;
        check("start in hold hs", bus.HS, 1);
        check("start in hold h_pos", bus.H_POS, 0);
        ticks(3);
        check("pre reset h_pos", bus.H_POS, 6);

        // Reset mid-H_SWEEP aborts on the next edge.
        rst = 1'b1;
        cyc(1);
        check("abort h_pos", bus.H_POS, 90);
        check("abort v_pos", bus.V_POS, 90);
        check("abort hs/busy/done", {bus.HS, bus.BUSY, bus.DONE}, 0);
        check("abort best", bus.BEST_LIGHT, 0);
        cyc(2);
        rst = 1'b0;
        ticks(2);
        check("idle after abort", {bus.HS, bus.BUSY}, 0);
        check("no done on abort", done_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
